slicel_config_loader: RTL and testbench
=======================================

// Module: slicel_config_loader
// PURPOSE
//  Configuration-side writer for one slicel. Accepts a word-serial bitstream over a
//  valid/ready stream, assembles the slice's full configuration image in a shadow
//  register, checks a trailing XOR checksum, then commits the image by pulsing cen
//  for exactly one cclk cycle. Outputs drive the slice's LUT, mux and carry-chain config inputs.
// PARAMETERS
//  S_XX_BASE  4                     LUT base input count; CFG_SIZE = 2**S_XX_BASE+1
//  NUM_LUTS   4                     LUTs per slice (power of 2); MUX_LVLS = $clog2(NUM_LUTS)
//  WORD_W     32                    bitstream word width
//  derived: TOTAL_BITS = NUM_LUTS*2*CFG_SIZE + MUX_LVLS + 1 (139 at defaults)
//           NUM_WORDS  = ceil(TOTAL_BITS/WORD_W) (5 at defaults)
// PORTS
//  cclk              in   1                       configuration clock, the block's only clock
//  rst_n             in   1                       asynchronous, active-low reset
//  cfg_start         in   1                       1-cycle pulse: begin (or restart) a frame
//  cfg_data          in   WORD_W                  bitstream word
//  cfg_valid         in   1                       cfg_data valid
//  cfg_ready         out  1                       loader accepts a word this cycle
//  luts_config_out   out  [2*CFG_SIZE-1:0] x NUM_LUTS   per-LUT config to slice luts_config_in
//  mux_config_out    out  MUX_LVLS                to slice inter_lut_mux_config
//  use_cc_out        out  1                       to slice config_use_cc
//  cen               out  1                       commit strobe to slice cen
//  busy              out  1                       frame in progress
//  done              out  1                       sticky: last frame committed
//  err               out  1                       sticky: last frame failed checksum
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; shadow image, all config outputs, cen, busy, done, err = 0; cfg_ready = 0.
//  - Image packing: bit 0 = use_cc; bits [MUX_LVLS:1] = mux config; then LUT0 config, LUT1, ... ascending.
//    Word k fills image bits [k*WORD_W +: WORD_W]; bits at or above TOTAL_BITS in the last word are ignored.
//  - Transfer: a word is consumed on a cclk edge with cfg_valid && cfg_ready. cfg_ready is
//    combinational from state only (1 in LOAD and CHECK, 0 otherwise); never depends on cfg_valid.
//  - FSM:
//    IDLE   : cfg_start -> LOAD; word counter = 0, checksum accumulator = 0; done, err cleared.
//    LOAD   : each accepted word written into shadow slice k, accumulator ^= word, k++;
//             after word NUM_WORDS-1 -> CHECK.
//    CHECK  : accepted word compared with accumulator; equal -> COMMIT; unequal -> IDLE, err=1.
//    COMMIT : cen=1 for this cycle only; next cycle -> IDLE, done=1.
//  - busy = 1 in LOAD, CHECK, COMMIT.
//  - Config outputs are driven directly from the shadow image at all times; they are stable
//    throughout COMMIT, so the slice captures the full image at the cen edge. cen never asserts on error.
//  - cfg_start in LOAD or CHECK: abort, restart at word 0, accumulator cleared; the word
//    presented that cycle is not consumed. cfg_start in COMMIT is ignored (commit completes).
//  - cfg_valid with no handshake in progress (IDLE/COMMIT): ignored, no state change.
//  - Stalls: cfg_valid low any number of cycles in LOAD/CHECK holds state indefinitely.
//  - Aborted or failed frames leave partially-updated shadow content; slice unaffected (no cen).
//  - Minimum frame latency: start + NUM_WORDS+1 transfer cycles + 1 commit cycle.
// STRUCTURE
//  - Package slicel_cfg_pkg: CFG_SIZE/MUX_LVLS/TOTAL_BITS/NUM_WORDS derivation functions,
//    loader state enum {IDLE, LOAD, CHECK, COMMIT}, image field offset constants.
//  - One natural sub-module: cfg_xor_accum (WORD_W-wide clear/accumulate register + compare).
//  - Remainder: FSM, word counter ($clog2(NUM_WORDS+1) bits), shadow image register, output slicing.
// TESTING
//  1 Reset: rst_n low mid-LOAD -> next cycle all outputs 0, cfg_ready 0, state IDLE; no cen.
//  2 Good frame: start, words 0x00000001,0x0,0x0,0x0,0x0 then checksum 0x00000001 -> one cen pulse,
//    use_cc_out=1, all others 0, done=1, err=0.
//  3 Bad checksum: same 5 words, checksum 0x00000000 -> err=1, done=0, cen never high.
//  4 Backpressure: cfg_valid toggled 1/0 each cycle across frame -> identical image, cen once.
//  5 Restart: cfg_start after 3 words, then full frame of 0xFFFFFFFF x5 + checksum 0xFFFFFFFF ->
//    all LUT configs all-ones, mux_config_out=2'b11, use_cc_out=1; pad bits ignored.
//  6 Field order: word 0 = 0x00000006 -> mux_config_out=2'b11, use_cc_out=0, LUT0 config 0.

Source files
------------

// File: rtl/slicel_cfg_pkg.sv
// rtl/slicel_cfg_pkg.sv - shared types, field offsets and size derivations for the slicel config loader
package slicel_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } loader_state_e;

  // Image layout: use_cc at bit 0, mux levels directly above, LUT configs after that.
  localparam int USE_CC_OFF = 0;
  localparam int MUX_OFF    = 1;

  function automatic int cfg_size(input int s_xx_base);
    return (2 ** s_xx_base) + 1;
  endfunction

  function automatic int mux_lvls(input int num_luts);
    return $clog2(num_luts);
  endfunction

  function automatic int lut_off(input int num_luts);
    return MUX_OFF + mux_lvls(num_luts);
  endfunction

  function automatic int total_bits(input int s_xx_base, input int num_luts);
    return num_luts * 2 * cfg_size(s_xx_base) + mux_lvls(num_luts) + 1;
  endfunction

  function automatic int num_words(input int s_xx_base, input int num_luts, input int word_w);
    return (total_bits(s_xx_base, num_luts) + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_xor_accum.sv
// rtl/cfg_xor_accum.sv - running XOR checksum register with equality compare against the incoming word
module cfg_xor_accum #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic              match
);

  logic [WORD_W-1:0] acc_q, acc_d;

  // Clear has priority so a restart never folds the dropped word into the new frame.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (din == acc_q);

endmodule

// File: rtl/slicel_config_loader.sv
// rtl/slicel_config_loader.sv - word-serial loader that assembles, checksums and commits a slicel config image
module slicel_config_loader
  import slicel_cfg_pkg::*;
#(
  parameter  int S_XX_BASE  = 4,
  parameter  int NUM_LUTS   = 4,
  parameter  int WORD_W     = 32,
  localparam int CFG_SIZE   = cfg_size(S_XX_BASE),
  localparam int MUX_LVLS   = mux_lvls(NUM_LUTS),
  localparam int LUT_W      = 2 * CFG_SIZE
) (
  input  logic                             cclk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic [WORD_W-1:0]                cfg_data,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic [NUM_LUTS-1:0][LUT_W-1:0]   luts_config_out,
  output logic [MUX_LVLS-1:0]              mux_config_out,
  output logic                             use_cc_out,
  output logic                             cen,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int TOTAL_BITS = total_bits(S_XX_BASE, NUM_LUTS);
  localparam int NUM_WORDS  = num_words(S_XX_BASE, NUM_LUTS, WORD_W);
  localparam int CNT_W      = $clog2(NUM_WORDS + 1);
  localparam int LUT_OFF    = lut_off(NUM_LUTS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  loader_state_e          state_q, state_d;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [TOTAL_BITS-1:0]  image_q, image_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   acc_clr, acc_en, acc_match;

  cfg_xor_accum #(
    .WORD_W (WORD_W)
  ) u_accum (
    .clk   (cclk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (cfg_data),
    .match (acc_match)
  );

  // State, word counter, shadow image and sticky status registers.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      image_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      image_q <= image_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state and datapath updates; a start pulse in LOAD/CHECK wins over the word on the bus.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    image_d = image_q;
    done_d  = done_q;
    err_d   = err_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
          acc_clr = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cfg_start) begin
          wcnt_d  = '0;
          acc_clr = 1'b1;
        end else if (cfg_valid) begin
          // Pad bits of the last word have no home in the image and simply fall away.
          for (int b = 0; b < TOTAL_BITS; b++) begin
            if (wcnt_q == CNT_W'(b / WORD_W)) begin
              image_d[b] = cfg_data[b % WORD_W];
            end
          end
          acc_en = 1'b1;
          wcnt_d = wcnt_q + CNT_W'(1);
          if (wcnt_q == LAST_WORD) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
          acc_clr = 1'b1;
        end else if (cfg_valid) begin
          if (acc_match) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and strobes depend on state alone, never on cfg_valid.
  always_comb begin
    cfg_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    busy      = (state_q != ST_IDLE);
    cen       = (state_q == ST_COMMIT);
  end

  assign done           = done_q;
  assign err            = err_q;
  assign use_cc_out     = image_q[USE_CC_OFF];
  assign mux_config_out = image_q[MUX_OFF +: MUX_LVLS];

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut_out
    assign luts_config_out[i] = image_q[LUT_OFF + i*LUT_W +: LUT_W];
  end

endmodule

// File: tb/tb_slicel_config_loader.sv
// tb/tb_slicel_config_loader.sv - randomized scoreboard bench for slicel_config_loader
module tb_slicel_config_loader;

  localparam int NW    = 5;
  localparam int NLUT  = 4;
  localparam int LUT_W = 34;

  typedef struct {
    bit           commit;
    logic [159:0] img;
  } exp_t;

  logic                       cclk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       cfg_start = 1'b0;
  logic                       cfg_valid = 1'b0;
  logic [31:0]                cfg_data = '0;
  logic                       cfg_ready;
  logic [NLUT-1:0][LUT_W-1:0] luts;
  logic [1:0]                 mux;
  logic                       use_cc, cen, busy, done, err;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [159:0] shadow = '0;
  int           n_vec = 0;
  int           n_fail = 0;
  int           n_pushed = 0;
  int           frames_seen = 0;
  int           cen_cnt = 0;
  bit           prev_busy = 1'b0;

  always #5 cclk = ~cclk;

  slicel_config_loader dut (
    .cclk            (cclk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_data        (cfg_data),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .luts_config_out (luts),
    .mux_config_out  (mux),
    .use_cc_out      (use_cc),
    .cen             (cen),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic note_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event not expected by scoreboard", name);
  endtask

  // Expected fields come straight from the image layout: bit 0, bits 2:1, then 34-bit LUT slices.
  task automatic chk_image(input string tag, input logic [159:0] e);
    chk($sformatf("%s.use_cc", tag), 64'(use_cc), 64'(e[0]));
    chk($sformatf("%s.mux", tag), 64'(mux), 64'(e[2:1]));
    for (int i = 0; i < NLUT; i++) begin
      chk($sformatf("%s.lut%0d", tag, i), 64'(luts[i]), 64'(e[3 + LUT_W*i +: LUT_W]));
    end
  endtask

  // Monitor: checks the image at every commit strobe and the status when a frame ends.
  always @(negedge cclk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      cen_cnt   = 0;
    end else begin
      if (cen) begin
        cen_cnt++;
        if (exp_q.size() == 0) begin
          note_fail("cen_unexpected");
        end else begin
          chk("cen_on_good_frame", 64'(exp_q[0].commit), 64'(1));
          chk_image("at_cen", exp_q[0].img);
        end
      end
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          note_fail("frame_end_unexpected");
        end else begin
          mon_e = exp_q.pop_front();
          chk("done", 64'(done), 64'(mon_e.commit));
          chk("err", 64'(err), 64'(!mon_e.commit));
          chk("cen_count", 64'(cen_cnt), 64'(mon_e.commit ? 1 : 0));
          chk_image("after_frame", mon_e.img);
          frames_seen++;
        end
        cen_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic start_pulse(input bit with_junk);
    cfg_start = 1'b1;
    if (with_junk) begin
      cfg_valid = 1'b1;
      cfg_data  = $urandom;
    end
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, output bit ok);
    int   guard;
    logic rdy;
    guard = 0;
    ok    = 1'b0;
    if (gap) begin
      cfg_valid = 1'b0;
      tick();
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!ok && guard < 50) begin
      rdy = cfg_ready;
      tick();
      if (rdy) ok = 1'b1;
      guard++;
    end
    cfg_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL handshake_timeout: got no ready, want ready within 50 cycles");
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("frame_completed", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  // One frame: optional abort after some words, then five words and a checksum xored with bad_mask.
  task automatic run_frame(input logic [31:0] w[NW], input logic [31:0] bad_mask,
                           input bit bp, input int abort_after);
    bit          ok;
    logic [31:0] x;
    logic [31:0] junk;
    x = '0;
    start_pulse(1'b0);
    if (abort_after >= 0) begin
      for (int k = 0; k < abort_after; k++) begin
        junk = $urandom;
        send_word(junk, bp, ok);
        if (ok) shadow[k*32 +: 32] = junk;
      end
      start_pulse(1'b1);
    end
    for (int k = 0; k < NW; k++) begin
      send_word(w[k], bp, ok);
      if (ok) shadow[k*32 +: 32] = w[k];
      x ^= w[k];
    end
    exp_q.push_back('{commit: (bad_mask == 0), img: shadow});
    n_pushed++;
    send_word(x ^ bad_mask, bp, ok);
    drain();
  endtask

  logic [31:0] fw[NW];
  bit          ok0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Good frame: only use_cc set.
    fw = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    run_frame(fw, 32'h0, 1'b0, -1);

    // Reset in the middle of a load clears everything, including the previous done.
    start_pulse(1'b0);
    send_word(32'hDEADBEEF, 1'b0, ok0);
    send_word(32'h12345678, 1'b0, ok0);
    rst_n = 1'b0;
    #1;
    shadow = '0;
    chk("rst.cfg_ready", 64'(cfg_ready), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.cen", 64'(cen), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    chk_image("rst", shadow);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Bad checksum: same payload, checksum 0.
    run_frame(fw, 32'h1, 1'b0, -1);

    // Backpressure: valid toggles every cycle.
    run_frame(fw, 32'h0, 1'b1, -1);

    // Restart after three words, then all-ones frame.
    fw = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_frame(fw, 32'h0, 1'b0, 3);

    // Field order: value 6 lands in the mux field only.
    fw = '{32'h6, 32'h0, 32'h0, 32'h0, 32'h0};
    run_frame(fw, 32'h0, 1'b0, -1);

    // Valid while idle must not touch the shadow image.
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_data = $urandom;
      tick();
    end
    cfg_valid = 1'b0;
    chk("idle.cfg_ready", 64'(cfg_ready), 64'(0));
    chk("idle.busy", 64'(busy), 64'(0));
    chk_image("idle_valid", shadow);

    // Random frames with random backpressure, errors and restarts.
    for (int f = 0; f < 20; f++) begin
      logic [31:0] mask;
      int          ab;
      for (int k = 0; k < NW; k++) fw[k] = $urandom;
      mask = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0;
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_frame(fw, mask, 1'($urandom_range(0, 1)), ab);
    end

    chk("frames_seen", 64'(frames_seen), 64'(n_pushed));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
